// File: rtl/axis_video_pattern_gen.sv
// AXI4-Stream video test-pattern source: solid colour, ramp, colour bars and checkerboard.
// Optional macro AXIS_VIDEO_PATGEN_BLANK_EN adds cfg_blank and an inter-line BLANK state.
module axis_video_pattern_gen #(
  parameter int PIXEL_PER_CLK  = 1,
  parameter int BITS_PER_PIXEL = 32,
  parameter int MAX_DIM        = 4096,
  parameter int BAR_SHIFT      = 7
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    enable,
  input  logic [1:0]                              mode,
  input  logic [15:0]                             cfg_width,
  input  logic [15:0]                             cfg_height,
  input  logic [BITS_PER_PIXEL-1:0]               solid_color,
`ifdef AXIS_VIDEO_PATGEN_BLANK_EN
  input  logic [7:0]                              cfg_blank,
`endif
  output logic                                    frame_done,
  output logic                                    busy,
  output logic                                    cfg_error,
  output logic [BITS_PER_PIXEL*PIXEL_PER_CLK-1:0] m_axis_video_out_tdata,
  output logic                                    m_axis_video_out_tvalid,
  output logic                                    m_axis_video_out_tlast,
  output logic                                    m_axis_video_out_tuser,
  input  logic                                    m_axis_video_out_tready
);
  localparam int          DW       = BITS_PER_PIXEL * PIXEL_PER_CLK;
  localparam logic [15:0] PPC      = 16'(PIXEL_PER_CLK);
  localparam logic [15:0] PPC_MASK = 16'(PIXEL_PER_CLK - 1);
  localparam logic [15:0] MAX_D    = 16'(MAX_DIM);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
`ifdef AXIS_VIDEO_PATGEN_BLANK_EN
    BLANK  = 2'd2,
`endif
    ACTIVE = 2'd1
  } state_e;

  function automatic logic [BITS_PER_PIXEL-1:0] pixel_f(input logic [1:0] m, input logic [15:0] x,
                                                         input logic y4,
                                                         input logic [BITS_PER_PIXEL-1:0] color);
    logic [23:0] rgb;
    logic [2:0]  bar;
    bar = 3'(x >> BAR_SHIFT);
    rgb = 24'h000000;
    case (m)
      2'd1: rgb = {3{x[7:0]}};
      2'd2: begin
        case (bar)
          3'd0:    rgb = 24'hFFFFFF;
          3'd1:    rgb = 24'hFFFF00;
          3'd2:    rgb = 24'h00FFFF;
          3'd3:    rgb = 24'h00FF00;
          3'd4:    rgb = 24'hFF00FF;
          3'd5:    rgb = 24'hFF0000;
          3'd6:    rgb = 24'h0000FF;
          default: rgb = 24'h000000;
        endcase
      end
      2'd3:    rgb = (x[4] ^ y4) ? 24'hFFFFFF : 24'h000000;
      default: rgb = 24'h000000;
    endcase
    return (m == 2'd0) ? color : BITS_PER_PIXEL'(rgb);
  endfunction

  // Lane i carries pixel x+i, lowest x in the least significant lane
  function automatic logic [DW-1:0] beat_f(input logic [1:0] m, input logic [15:0] x, input logic y4,
                                           input logic [BITS_PER_PIXEL-1:0] color);
    logic [DW-1:0] d;
    d = '0;
    for (int i = 0; i < PIXEL_PER_CLK; i++) begin
      d[i*BITS_PER_PIXEL +: BITS_PER_PIXEL] = pixel_f(m, x + 16'(i), y4, color);
    end
    return d;
  endfunction

  state_e                    state_q, state_d;
  logic [15:0]               x_q, x_d, y_q, y_d;
  logic [1:0]                mode_q, mode_d;
  logic [15:0]               width_q, width_d, height_q, height_d;
  logic [BITS_PER_PIXEL-1:0] color_q, color_d;
`ifdef AXIS_VIDEO_PATGEN_BLANK_EN
  logic [7:0]                blank_q, blank_d, blank_cnt_q, blank_cnt_d;
`endif
  logic [DW-1:0]             tdata_q, tdata_d;
  logic                      tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
  logic                      done_q, done_d, busy_q, busy_d, cfg_err_q, cfg_err_d;
  logic                      cfg_legal_s, hs_s, last_line_s;

  assign cfg_legal_s = (cfg_width != 16'd0) && (cfg_height != 16'd0) && (cfg_width <= MAX_D) &&
                       (cfg_height <= MAX_D) && ((cfg_width & PPC_MASK) == 16'd0);
  assign hs_s        = tvalid_q && m_axis_video_out_tready;
  assign last_line_s = (y_q == (height_q - 16'd1));

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable && cfg_legal_s) state_d = ACTIVE;
        else                       state_d = IDLE;
      end
      ACTIVE: begin
        if (hs_s && tlast_q) begin
          if (last_line_s)          state_d = IDLE;
`ifdef AXIS_VIDEO_PATGEN_BLANK_EN
          else if (blank_q != 8'd0) state_d = BLANK;
`endif
          else                      state_d = ACTIVE;
        end else begin
          state_d = ACTIVE;
        end
      end
`ifdef AXIS_VIDEO_PATGEN_BLANK_EN
      BLANK: begin
        if (blank_cnt_q == 8'd1) state_d = ACTIVE;
        else                     state_d = BLANK;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs and datapath next values; configuration tracks the inputs only while idle
  always_comb begin
    mode_d   = mode_q;
    width_d  = width_q;
    height_d = height_q;
    color_d  = color_q;
    x_d      = x_q;
    y_d      = y_q;
`ifdef AXIS_VIDEO_PATGEN_BLANK_EN
    blank_d  = blank_q;
    if (state_q == ACTIVE)     blank_cnt_d = blank_q;
    else if (state_q == BLANK) blank_cnt_d = blank_cnt_q - 8'd1;
    else                       blank_cnt_d = blank_cnt_q;
`endif
    if (state_q == IDLE) begin
      mode_d   = mode;
      width_d  = cfg_width;
      height_d = cfg_height;
      color_d  = solid_color;
`ifdef AXIS_VIDEO_PATGEN_BLANK_EN
      blank_d  = cfg_blank;
`endif
      x_d      = 16'd0;
      y_d      = 16'd0;
    end else if ((state_q == ACTIVE) && hs_s) begin
      if (tlast_q) begin
        x_d = 16'd0;
        y_d = last_line_s ? 16'd0 : (y_q + 16'd1);
      end else begin
        x_d = x_q + PPC;
        y_d = y_q;
      end
    end else begin
      x_d = x_q;
      y_d = y_q;
    end
    tvalid_d  = (state_d == ACTIVE);
    busy_d    = (state_d != IDLE);
    tuser_d   = tvalid_d && (x_d == 16'd0) && (y_d == 16'd0);
    tlast_d   = tvalid_d && (x_d == (width_d - PPC));
    tdata_d   = busy_d ? beat_f(mode_d, x_d, y_d[4], color_d) : '0;
    done_d    = (state_q == ACTIVE) && hs_s && tlast_q && last_line_s;
    cfg_err_d = (state_d == IDLE) && !cfg_legal_s;
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q         <= 16'd0;
      y_q         <= 16'd0;
      mode_q      <= 2'd0;
      width_q     <= 16'd0;
      height_q    <= 16'd0;
      color_q     <= '0;
`ifdef AXIS_VIDEO_PATGEN_BLANK_EN
      blank_q     <= 8'd0;
      blank_cnt_q <= 8'd0;
`endif
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tuser_q     <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      mode_q      <= mode_d;
      width_q     <= width_d;
      height_q    <= height_d;
      color_q     <= color_d;
`ifdef AXIS_VIDEO_PATGEN_BLANK_EN
      blank_q     <= blank_d;
      blank_cnt_q <= blank_cnt_d;
`endif
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      tuser_q     <= tuser_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign m_axis_video_out_tdata  = tdata_q;
  assign m_axis_video_out_tvalid = tvalid_q;
  assign m_axis_video_out_tlast  = tlast_q;
  assign m_axis_video_out_tuser  = tuser_q;
  assign frame_done              = done_q;
  assign busy                    = busy_q;
  assign cfg_error               = cfg_err_q;
endmodule

// File: tb/tb_axis_video_pattern_gen.sv
// Directed bench for axis_video_pattern_gen: one PPC=1 instance and one PPC=4/BAR_SHIFT=2 instance.
module tb_axis_video_pattern_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: PPC=1, default parameters
  logic        a_en = 1'b0, a_tready = 1'b1;
  logic [1:0]  a_mode = 2'd1;
  logic [15:0] a_w = 16'd8, a_h = 16'd2;
  logic [31:0] a_color = 32'h0;
  logic [7:0]  a_blank = 8'd0;
  logic        a_done, a_busy, a_err, a_tvalid, a_tlast, a_tuser;
  logic [31:0] a_tdata;

  // Instance B: PPC=4, BAR_SHIFT=2
  logic         b_en = 1'b0, b_tready = 1'b1;
  logic [1:0]   b_mode = 2'd2;
  logic [15:0]  b_w = 16'd6, b_h = 16'd1;
  logic [31:0]  b_color = 32'h0;
  logic [7:0]   b_blank = 8'd0;
  logic         b_done, b_busy, b_err, b_tvalid, b_tlast, b_tuser;
  logic [127:0] b_tdata;

  axis_video_pattern_gen dut_a (
    .clk(clk), .rst(rst), .enable(a_en), .mode(a_mode), .cfg_width(a_w), .cfg_height(a_h),
    .solid_color(a_color),
`ifdef AXIS_VIDEO_PATGEN_BLANK_EN
    .cfg_blank(a_blank),
`endif
    .frame_done(a_done), .busy(a_busy), .cfg_error(a_err),
    .m_axis_video_out_tdata(a_tdata), .m_axis_video_out_tvalid(a_tvalid),
    .m_axis_video_out_tlast(a_tlast), .m_axis_video_out_tuser(a_tuser),
    .m_axis_video_out_tready(a_tready)
  );

  axis_video_pattern_gen #(.PIXEL_PER_CLK(4), .BAR_SHIFT(2)) dut_b (
    .clk(clk), .rst(rst), .enable(b_en), .mode(b_mode), .cfg_width(b_w), .cfg_height(b_h),
    .solid_color(b_color),
`ifdef AXIS_VIDEO_PATGEN_BLANK_EN
    .cfg_blank(b_blank),
`endif
    .frame_done(b_done), .busy(b_busy), .cfg_error(b_err),
    .m_axis_video_out_tdata(b_tdata), .m_axis_video_out_tvalid(b_tvalid),
    .m_axis_video_out_tlast(b_tlast), .m_axis_video_out_tuser(b_tuser),
    .m_axis_video_out_tready(b_tready)
  );

  int tests = 0;
  int fails = 0;
  logic [31:0] bd [64];
  logic [31:0] refd [16];
  bit          bu [64];
  bit          bl [64];
  int          bc [64];
  int          nb, nd, dc;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Run instance A for a fixed number of cycles, recording completed beats and stall stability
  task automatic run_a(input int cycles, input bit rnd);
    logic [31:0] hd;
    bit hu, hl, held;
    nb = 0; nd = 0; dc = -1; held = 1'b0; hd = 32'h0; hu = 1'b0; hl = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      if (a_done) begin nd++; dc = c; end
      if (held) begin
        check("stall_tdata", 256'(a_tdata), 256'(hd));
        check("stall_tuser", 256'(a_tuser), 256'(hu));
        check("stall_tlast", 256'(a_tlast), 256'(hl));
      end
      if (a_tvalid) begin
        a_en = 1'b0;
        check("busy_in_frame", 256'(a_busy), 256'(1));
      end
      a_tready = rnd ? ($urandom_range(0, 1) != 0) : 1'b1;
      if (a_tvalid && a_tready) begin
        if (nb < 64) begin
          bd[nb] = a_tdata; bu[nb] = a_tuser; bl[nb] = a_tlast; bc[nb] = c;
        end
        nb++;
        held = 1'b0;
      end else if (a_tvalid) begin
        held = 1'b1; hd = a_tdata; hu = a_tuser; hl = a_tlast;
      end else begin
        held = 1'b0;
      end
    end
    a_tready = 1'b1;
  endtask

  initial begin
    logic [7:0]   xv;
    logic [127:0] b_bd [8];
    bit           b_bl [8];
    int           b_nb, b_nd;

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    check("rst_tvalid", 256'(a_tvalid), 256'(0));
    check("rst_busy", 256'(a_busy), 256'(0));
    check("rst_tdata", 256'(a_tdata), 256'(0));
    check("rst_flags", 256'({a_tuser, a_tlast, a_done, a_err}), 256'(0));
    rst = 1'b0;

    // Ramp 8x2, tready=1
    a_en = 1'b1;
    run_a(40, 1'b0);
    check("ramp_beats", 256'(nb), 256'(16));
    check("ramp_done_cnt", 256'(nd), 256'(1));
    for (int k = 0; k < 16; k++) begin
      xv = 8'(k % 8);
      check("ramp_tdata", 256'(bd[k]), 256'({8'h00, xv, xv, xv}));
      check("ramp_tuser", 256'(bu[k]), 256'(k == 0));
      check("ramp_tlast", 256'(bl[k]), 256'((k % 8) == 7));
      refd[k] = bd[k];
    end
    check("ramp_back_to_back", 256'(bc[15] - bc[0]), 256'(15));
    check("ramp_done_pos", 256'(dc), 256'(bc[15] + 1));
    check("ramp_end_tvalid", 256'(a_tvalid), 256'(0));
    check("ramp_end_busy", 256'(a_busy), 256'(0));

    // Same frame with random backpressure
    a_en = 1'b1;
    run_a(300, 1'b1);
    check("bp_beats", 256'(nb), 256'(16));
    check("bp_done_cnt", 256'(nd), 256'(1));
    for (int k = 0; k < 16; k++) begin
      check("bp_tdata", 256'(bd[k]), 256'(refd[k]));
      check("bp_tuser", 256'(bu[k]), 256'(k == 0));
      check("bp_tlast", 256'(bl[k]), 256'((k % 8) == 7));
    end

    // Solid colour 4x1
    a_mode = 2'd0; a_w = 16'd4; a_h = 16'd1; a_color = 32'h00123456; a_en = 1'b1;
    run_a(20, 1'b0);
    check("solid_beats", 256'(nb), 256'(4));
    check("solid_px0", 256'(bd[0]), 256'(32'h00123456));
    check("solid_px3", 256'(bd[3]), 256'(32'h00123456));
    check("solid_tlast", 256'({bl[3], bl[2], bu[0]}), 256'(3'b101));

    // Checkerboard 32x1: x[4] selects white
    a_mode = 2'd3; a_w = 16'd32; a_en = 1'b1;
    run_a(50, 1'b0);
    check("chk_beats", 256'(nb), 256'(32));
    check("chk_px15", 256'(bd[15]), 256'(32'h00000000));
    check("chk_px16", 256'(bd[16]), 256'(32'h00FFFFFF));
    check("chk_px31", 256'(bd[31]), 256'(32'h00FFFFFF));

    // Reset at beat 5 of a ramp frame
    a_mode = 2'd1; a_w = 16'd8; a_h = 16'd2; a_en = 1'b1; nb = 0;
    for (int c = 0; c < 40 && nb < 6; c++) begin
      @(posedge clk); #1;
      if (a_tvalid) begin a_en = 1'b0; nb++; end
    end
    check("mid_beat5_seen", 256'(nb), 256'(6));
    check("mid_beat5_data", 256'(a_tdata), 256'(32'h00050505));
    #2 rst = 1'b1;
    #1;
    check("mid_rst_tvalid", 256'(a_tvalid), 256'(0));
    check("mid_rst_tdata", 256'(a_tdata), 256'(0));
    check("mid_rst_flags", 256'({a_tuser, a_tlast, a_done, a_busy, a_err}), 256'(0));
    @(posedge clk); #1;
    rst = 1'b0; a_en = 1'b1;
    run_a(40, 1'b0);
    check("post_rst_beats", 256'(nb), 256'(16));
    check("post_rst_tuser", 256'(bu[0]), 256'(1));
    check("post_rst_tdata", 256'(bd[0]), 256'(32'h00000000));

    // Width 6 with PPC=4 is illegal
    b_en = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bad_cfg_error", 256'(b_err), 256'(1));
      check("bad_cfg_tvalid", 256'(b_tvalid), 256'(0));
      check("bad_cfg_busy", 256'(b_busy), 256'(0));
    end

    // Colour bars, PPC=4, 4-pixel bars, width 16
    b_w = 16'd16; b_nb = 0; b_nd = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (b_done) b_nd++;
      if (b_tvalid) begin
        b_en = 1'b0;
        if (b_nb < 8) begin b_bd[b_nb] = b_tdata; b_bl[b_nb] = b_tlast; end
        b_nb++;
      end
    end
    check("bars_beats", 256'(b_nb), 256'(4));
    check("bars_done_cnt", 256'(b_nd), 256'(1));
    check("bars_beat0", 256'(b_bd[0]), 256'({4{32'h00FFFFFF}}));
    check("bars_beat1", 256'(b_bd[1]), 256'({4{32'h00FFFF00}}));
    check("bars_beat2", 256'(b_bd[2]), 256'({4{32'h0000FFFF}}));
    check("bars_beat3", 256'(b_bd[3]), 256'({4{32'h0000FF00}}));
    check("bars_tlast", 256'({b_bl[3], b_bl[2], b_bl[1], b_bl[0]}), 256'(4'b1000));
    check("bars_cfg_error", 256'(b_err), 256'(0));

`ifdef AXIS_VIDEO_PATGEN_BLANK_EN
    // Three blank cycles between lines, none after the last line
    a_blank = 8'd3; a_en = 1'b1;
    run_a(60, 1'b0);
    check("blank_beats", 256'(nb), 256'(16));
    check("blank_gap", 256'(bc[8] - bc[7] - 1), 256'(3));
    check("blank_line0", 256'(bc[7] - bc[0]), 256'(7));
    check("blank_done_pos", 256'(dc), 256'(bc[15] + 1));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/axis_video_pattern_gen.md
AXIS_VIDEO_PATTERN_GEN -- requirements
Module: axis_video_pattern_gen

Interface
REQ-001 SHALL have parameter PIXEL_PER_CLK, default 1, pixels per beat; legal values are 1, 2, 4 and 8.
REQ-002 SHALL have parameter BITS_PER_PIXEL, default 32, pixel width; legal values are at least 24.
REQ-003 SHALL have parameter MAX_DIM, default 4096, largest legal width or height.
REQ-004 SHALL have parameter BAR_SHIFT, default 7, log2 of the colour-bar width in pixels.
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port enable, input, 1 bit: frame generation request, level-sensitive.
REQ-008 SHALL have port mode, input, 2 bits: 0 solid, 1 ramp, 2 colour bars, 3 checkerboard.
REQ-009 SHALL have ports cfg_width and cfg_height, input, 16 bits each: frame size in pixels and lines.
REQ-010 SHALL have port solid_color, input, BITS_PER_PIXEL bits: the colour used in mode 0.
REQ-011 SHALL have port frame_done, output, 1 bit: one-cycle pulse after a frame's last beat.
REQ-012 SHALL have port busy, output, 1 bit: high while a frame is in progress.
REQ-013 SHALL have port cfg_error, output, 1 bit: high while idle and the configuration is illegal.
REQ-014 SHALL have ports m_axis_video_out_tdata (output, BITS_PER_PIXEL*PIXEL_PER_CLK bits), m_axis_video_out_tvalid, _tlast, _tuser (outputs) and _tready (input): AXI4-Stream video master.

Function
REQ-015 SHALL implement an FSM with states IDLE, ACTIVE and BLANK (BLANK only under REQ-030).
REQ-016 SHALL, in IDLE with enable=1 and a legal configuration, latch mode, width, height and solid_color and enter ACTIVE on the next cycle.
REQ-017 SHALL treat a configuration as legal only if width and height are non-zero and at most MAX_DIM, and width is a multiple of PIXEL_PER_CLK; otherwise it stays in IDLE with cfg_error=1.
REQ-018 SHALL ignore changes to configuration inputs while not in IDLE.
REQ-019 SHALL drive all outputs from registers; tvalid=1 throughout ACTIVE.
REQ-020 SHALL complete a beat only when tvalid and tready are both 1, and SHALL hold tdata, tuser and tlast stable while tvalid=1 and tready=0.
REQ-021 SHALL place pixel x+i in lane i (bits i*BPP upward), so lane 0 carries the lowest x.
REQ-022 SHALL assert tuser only on beat x=0, y=0, and tlast only on the beat where x = width-PIXEL_PER_CLK.
REQ-023 SHALL advance x by PIXEL_PER_CLK per completed beat, wrap x to 0 and increment y at tlast, and end the frame at tlast of line height-1.
REQ-024 SHALL, on frame end, pulse frame_done for one cycle, deassert tvalid and return to IDLE; IDLE lasts at least one cycle between frames.
REQ-025 SHALL, if enable falls mid-frame, finish the current frame in full and start no new frame.
REQ-026 SHALL generate pixel values (low 24 bits RGB 0xRRGGBB, upper bits 0) as follows:
  mode 0: solid_color;
  mode 1: each of the three bytes equals x[7:0];
  mode 2: bar (x>>BAR_SHIFT)%8 from the table white, yellow, cyan, green, magenta, red, blue, black (FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000);
  mode 3: FFFFFF if x[4]^y[4] is 1, else 000000.
REQ-027 SHALL keep busy=1 from the cycle ACTIVE is entered until the cycle IDLE is re-entered.

Reset
REQ-028 SHALL, on rst=1 and asynchronously, clear tdata, tvalid, tlast, tuser, frame_done, busy and cfg_error to 0 and return to IDLE with x=0, y=0.
REQ-029 SHALL, on reset mid-frame, abandon the partial frame; the next frame starts at x=0, y=0 with tuser=1.

Configuration
REQ-030 SHALL, when macro AXIS_VIDEO_PATGEN_BLANK_EN is defined, add input cfg_blank (8 bits, latched with the rest of the configuration) and, after each completed tlast beat except the frame's last, enter BLANK with tvalid=0 for cfg_blank cycles; cfg_blank=0 means no BLANK state.
REQ-031 SHALL, when AXIS_VIDEO_PATGEN_BLANK_EN is undefined, have no cfg_blank port and no BLANK state, so line beats may be back-to-back.

Verification
REQ-032 SHALL verify: PPC=1, width=8, height=2, mode 1, tready=1 -> 16 beats with tdata 0x000000..0x070707 per line, tuser on beat 0, tlast on beats 7 and 15, one frame_done.
REQ-033 SHALL verify: PPC=4, width=16, mode 2, BAR_SHIFT=2 -> beat 0 lanes all 0xFFFFFF, beat 1 lanes all 0xFFFF00, tlast on beat 3.
REQ-034 SHALL verify: tready toggles randomly -> tdata, tuser and tlast are unchanged across every stall, and the full pixel sequence matches the tready=1 run.
REQ-035 SHALL verify: width=6 with PPC=4 -> cfg_error=1, tvalid stays 0, and busy stays 0.
REQ-036 SHALL verify: rst pulsed at beat 5 of a frame -> all outputs are 0 in the same cycle, and the next frame begins with tuser=1 and tdata for x=0.
REQ-037 SHALL verify: with BLANK_EN and cfg_blank=3 -> exactly 3 tvalid=0 cycles between lines and none after the last line.
